// File: rtl/mem_align_unit_if.sv
// Bundles the CPU-side request/response signals and the backing-memory beat
// signals of mem_align_unit. The slave modport is the alignment unit's view;
// the master modport is the view of whatever drives requests and serves beats.
interface mem_align_unit_if #(
    parameter int BUS_W  = 16,
    parameter int ADDR_W = 32
);
    // CPU-side request
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_rw;
    logic [ADDR_W-1:0]    req_addr;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [31:0]          req_wdata;

    // CPU-side response
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_fault;

    // Backing-memory beat port
    logic                 mem_req;
    logic                 mem_rw;
    logic [ADDR_W-1:0]    mem_addr;
    logic [BUS_W/8-1:0]   mem_be;
    logic [BUS_W-1:0]     mem_wdata;
    logic                 mem_ack;
    logic [BUS_W-1:0]     mem_rdata;

    modport slave (
        input  req_valid, req_rw, req_addr, req_size, req_signed, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
        output mem_req, mem_rw, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_rw, req_addr, req_size, req_signed, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
        input  mem_req, mem_rw, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_align_unit.sv
// Load/store alignment engine. Splits byte/half/word accesses into the minimum
// number of BUS_W-aligned beats on the backing memory port, assembles
// little-endian read data with optional sign extension, and faults illegal or
// (when ALLOW_MISALIGNED=0) non-naturally-aligned requests without touching
// memory.
module mem_align_unit #(
    parameter int BUS_W            = 16,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic             clk,
    input logic             reset,
    mem_align_unit_if.slave bus
);
    localparam int unsigned B     = BUS_W / 8;
    localparam int unsigned OFF_W = $clog2(B);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              rw_q;
    logic              signed_q;
    logic              fault_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       rdata_q;
    logic [1:0]        beat_q;
    logic [1:0]        nbeats_q;

    // Request decode (only consumed in IDLE)
    logic [OFF_W-1:0]  req_off;
    logic [3:0]        req_nbytes;
    logic [3:0]        req_nbeats;
    logic              req_misaligned;
    logic              req_fault;

    // Per-beat lane mapping
    logic [3:0]        nbytes_q;
    logic [OFF_W-1:0]  off_q;
    logic [3:0]        pos;
    logic [3:0]        k;
    logic [1:0]        kk;
    logic [B-1:0]      be_c;
    logic [BUS_W-1:0]  wdata_c;
    logic [31:0]       asm_next;
    logic [ADDR_W-1:0] beat_addr;
    logic              last_beat;

    function automatic logic [31:0] extend(input logic [31:0] v,
                                           input logic [1:0]  sz,
                                           input logic        sgn);
        case (sz)
            2'd0:    extend = {{24{sgn & v[7]}}, v[7:0]};
            2'd1:    extend = {{16{sgn & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    // Decode incoming request: fault conditions and number of beats needed
    always_comb begin
        req_off    = bus.req_addr[OFF_W-1:0];
        req_nbytes = 4'd1 << bus.req_size;
        case (bus.req_size)
            2'd1:    req_misaligned = bus.req_addr[0];
            2'd2:    req_misaligned = |bus.req_addr[1:0];
            default: req_misaligned = 1'b0;
        endcase
        req_fault  = (bus.req_size == 2'd3) || (!ALLOW_MISALIGNED && req_misaligned);
        // ceil((offset + bytes) / B)
        req_nbeats = (4'(req_off) + req_nbytes + 4'(B - 1)) >> OFF_W;
    end

    assign nbytes_q  = 4'd1 << size_q;
    assign off_q     = addr_q[OFF_W-1:0];
    assign beat_addr = (addr_q & ~ADDR_W'(B - 1)) + (ADDR_W'(beat_q) << OFF_W);
    assign last_beat = (beat_q == nbeats_q - 2'd1);

    // Map request bytes onto lanes of the current beat; request byte k lives at
    // stream position off+k, so lane i of beat n carries k = n*B + i - off
    always_comb begin
        be_c     = '0;
        wdata_c  = '0;
        asm_next = asm_q;
        pos      = '0;
        k        = '0;
        kk       = '0;
        if (state_q == ACCESS) begin
            for (int unsigned i = 0; i < B; i++) begin
                pos = (4'(beat_q) << OFF_W) + 4'(i);
                k   = pos - 4'(off_q);
                kk  = k[1:0];
                if ((pos >= 4'(off_q)) && (k < nbytes_q)) begin
                    be_c[i]              = 1'b1;
                    wdata_c[8*i +: 8]    = 8'(wdata_q >> {kk, 3'b000});
                    asm_next[8*kk +: 8]  = bus.mem_rdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            rw_q     <= 1'b0;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            wdata_q  <= '0;
            asm_q    <= '0;
            rdata_q  <= '0;
            beat_q   <= '0;
            nbeats_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        size_q   <= bus.req_size;
                        rw_q     <= bus.req_rw;
                        signed_q <= bus.req_signed;
                        wdata_q  <= bus.req_wdata;
                        asm_q    <= '0;
                        beat_q   <= '0;
                        nbeats_q <= req_nbeats[1:0];
                        fault_q  <= req_fault;
                        if (req_fault) begin
                            rdata_q <= '0;
                            state_q <= RESP;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        asm_q  <= asm_next;
                        beat_q <= beat_q + 2'd1;
                        if (last_beat) begin
                            // response data is registered on entry to RESP so it
                            // holds afterwards; includes the final beat's lanes
                            rdata_q <= rw_q ? 32'd0 : extend(asm_next, size_q, signed_q);
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_fault = (state_q == RESP) && fault_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_req   = (state_q == ACCESS);
    assign bus.mem_rw    = (state_q == ACCESS) && rw_q;
    assign bus.mem_addr  = (state_q == ACCESS) ? beat_addr : '0;
    assign bus.mem_be    = be_c;
    assign bus.mem_wdata = rw_q ? wdata_c : '0;

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit: three instances cover a 16-bit bus with
// misaligned splitting, a 32-bit bus, and a 16-bit bus that faults misaligned
// requests. Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_align_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_align_unit_if #(.BUS_W(16), .ADDR_W(32)) bus_a ();
    mem_align_unit_if #(.BUS_W(32), .ADDR_W(32)) bus_b ();
    mem_align_unit_if #(.BUS_W(16), .ADDR_W(32)) bus_c ();

    mem_align_unit #(.BUS_W(16), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    mem_align_unit #(.BUS_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));
    mem_align_unit #(.BUS_W(16), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c));

    // Backing memories (read-only images, preloaded by the stimulus)
    logic [7:0]  mem_a [0:1023];
    logic [7:0]  mem_b [0:1023];
    logic [31:0] dly_addr_a;
    int unsigned wcnt_a;

    // Memory A: zero-wait except the beat at dly_addr_a, acked after 5 wait cycles
    always_comb begin
        bus_a.mem_ack   = bus_a.mem_req &&
                          ((bus_a.mem_addr != dly_addr_a) || (wcnt_a >= 5));
        bus_a.mem_rdata = {mem_a[bus_a.mem_addr[9:0] + 10'd1], mem_a[bus_a.mem_addr[9:0]]};
    end

    // Wait-state counter for memory A
    always_ff @(posedge clk) begin
        if (!bus_a.mem_req || bus_a.mem_ack) wcnt_a <= 0;
        else                                  wcnt_a <= wcnt_a + 1;
    end

    // Memory B: always zero-wait
    always_comb begin
        bus_b.mem_ack   = bus_b.mem_req;
        bus_b.mem_rdata = {mem_b[bus_b.mem_addr[9:0] + 10'd3], mem_b[bus_b.mem_addr[9:0] + 10'd2],
                           mem_b[bus_b.mem_addr[9:0] + 10'd1], mem_b[bus_b.mem_addr[9:0]]};
    end

    // Instance C never reaches memory
    assign bus_c.mem_ack   = 1'b0;
    assign bus_c.mem_rdata = '0;

    int n_asserts = 0;
    int n_fails   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic rw, input logic [31:0] addr,
                           input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        bus_a.req_valid = v; bus_a.req_rw = rw; bus_a.req_addr = addr;
        bus_a.req_size = sz; bus_a.req_signed = sg; bus_a.req_wdata = wd;
    endtask

    task automatic drive_b(input logic v, input logic rw, input logic [31:0] addr,
                           input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        bus_b.req_valid = v; bus_b.req_rw = rw; bus_b.req_addr = addr;
        bus_b.req_size = sz; bus_b.req_signed = sg; bus_b.req_wdata = wd;
    endtask

    task automatic drive_c(input logic v, input logic rw, input logic [31:0] addr,
                           input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        bus_c.req_valid = v; bus_c.req_rw = rw; bus_c.req_addr = addr;
        bus_c.req_size = sz; bus_c.req_signed = sg; bus_c.req_wdata = wd;
    endtask

    task automatic check_beat_a(input string tag, input logic rw, input logic [31:0] addr,
                                input logic [1:0] be, input logic [15:0] wd);
        check({tag, ".req"},   32'(bus_a.mem_req),   32'd1);
        check({tag, ".rw"},    32'(bus_a.mem_rw),    32'(rw));
        check({tag, ".addr"},  bus_a.mem_addr,       addr);
        check({tag, ".be"},    32'(bus_a.mem_be),    32'(be));
        check({tag, ".wdata"}, 32'(bus_a.mem_wdata), 32'(wd));
    endtask

    initial begin
        reset = 1'b1;
        dly_addr_a = 32'hFFFF_FFFF;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        drive_c(0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        tick();
        check("rst.ready_in_reset", 32'(bus_a.req_ready), 32'd0);
        check("rst.mem_req",        32'(bus_a.mem_req),   32'd0);
        reset = 1'b0;
        tick();
        check("rst.a_ready",  32'(bus_a.req_ready), 32'd1);
        check("rst.b_ready",  32'(bus_b.req_ready), 32'd1);
        check("rst.c_ready",  32'(bus_c.req_ready), 32'd1);
        check("rst.rsp_valid",32'(bus_a.rsp_valid), 32'd0);
        check("rst.rsp_fault",32'(bus_a.rsp_fault), 32'd0);
        check("rst.rdata",    bus_a.rsp_rdata,      32'd0);
        check("rst.be",       32'(bus_a.mem_be),    32'd0);
        check("rst.wdata",    32'(bus_a.mem_wdata), 32'd0);

        // 16-bit bus: misaligned word write to 0x101 splits into three beats
        drive_a(1, 1, 32'h101, 2'd2, 0, 32'hDDCC_BBAA);
        tick();
        drive_a(0, 0, 0, 0, 0, 0);
        check("wr.ready_busy", 32'(bus_a.req_ready), 32'd0);
        check_beat_a("wr.b0", 1, 32'h100, 2'b10, 16'hAA00);
        tick();
        check_beat_a("wr.b1", 1, 32'h102, 2'b11, 16'hCCBB);
        tick();
        check_beat_a("wr.b2", 1, 32'h104, 2'b01, 16'h00DD);
        check("wr.no_rsp_yet", 32'(bus_a.rsp_valid), 32'd0);
        tick();
        check("wr.rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
        check("wr.rsp_fault", 32'(bus_a.rsp_fault), 32'd0);
        check("wr.rdata",     bus_a.rsp_rdata,      32'd0);
        check("wr.mem_req",   32'(bus_a.mem_req),   32'd0);
        tick();
        check("wr.rsp_pulse", 32'(bus_a.rsp_valid), 32'd0);

        // 16-bit bus: byte read at 0x203, signed then unsigned
        mem_a[10'h202] = 8'h12;
        mem_a[10'h203] = 8'h80;
        drive_a(1, 0, 32'h203, 2'd0, 1, 32'h0);
        tick();
        drive_a(0, 0, 0, 0, 0, 0);
        check_beat_a("rdb.s", 0, 32'h202, 2'b10, 16'h0000);
        tick();
        check("rdb.s.valid", 32'(bus_a.rsp_valid), 32'd1);
        check("rdb.s.rdata", bus_a.rsp_rdata,      32'hFFFF_FF80);
        tick();
        drive_a(1, 0, 32'h203, 2'd0, 0, 32'h0);
        tick();
        drive_a(0, 0, 0, 0, 0, 0);
        check_beat_a("rdb.u", 0, 32'h202, 2'b10, 16'h0000);
        tick();
        check("rdb.u.valid", 32'(bus_a.rsp_valid), 32'd1);
        check("rdb.u.rdata", bus_a.rsp_rdata,      32'h0000_0080);
        tick();

        // Illegal size faults even when misaligned splitting is allowed; clears rdata
        drive_a(1, 0, 32'h000, 2'd3, 0, 32'h0);
        tick();
        drive_a(0, 0, 0, 0, 0, 0);
        check("a.sz3.valid",   32'(bus_a.rsp_valid), 32'd1);
        check("a.sz3.fault",   32'(bus_a.rsp_fault), 32'd1);
        check("a.sz3.rdata",   bus_a.rsp_rdata,      32'd0);
        check("a.sz3.mem_req", 32'(bus_a.mem_req),   32'd0);
        tick();

        // 32-bit bus: unsigned half read at 0x007 spans two beats
        mem_b[10'h007] = 8'h34;
        mem_b[10'h008] = 8'h12;
        drive_b(1, 0, 32'h007, 2'd1, 0, 32'h0);
        tick();
        drive_b(0, 0, 0, 0, 0, 0);
        check("b.h.b0.req",  32'(bus_b.mem_req), 32'd1);
        check("b.h.b0.addr", bus_b.mem_addr,     32'h004);
        check("b.h.b0.be",   32'(bus_b.mem_be),  32'b1000);
        tick();
        check("b.h.b1.addr", bus_b.mem_addr,     32'h008);
        check("b.h.b1.be",   32'(bus_b.mem_be),  32'b0001);
        tick();
        check("b.h.valid",   32'(bus_b.rsp_valid), 32'd1);
        check("b.h.rdata",   bus_b.rsp_rdata,      32'h0000_1234);
        tick();

        // 32-bit bus: back-to-back aligned word reads with req_valid held high
        mem_b[10'h010] = 8'h01; mem_b[10'h011] = 8'h02; mem_b[10'h012] = 8'h03; mem_b[10'h013] = 8'h04;
        mem_b[10'h014] = 8'h05; mem_b[10'h015] = 8'h06; mem_b[10'h016] = 8'h07; mem_b[10'h017] = 8'h08;
        drive_b(1, 0, 32'h010, 2'd2, 0, 32'h0);
        check("b2b.t0.ready", 32'(bus_b.req_ready), 32'd1);
        tick();
        check("b2b.t1.ready", 32'(bus_b.req_ready), 32'd0);
        check("b2b.t1.addr",  bus_b.mem_addr,       32'h010);
        check("b2b.t1.be",    32'(bus_b.mem_be),    32'b1111);
        drive_b(1, 0, 32'h014, 2'd2, 0, 32'h0);
        tick();
        check("b2b.t2.ready", 32'(bus_b.req_ready), 32'd0);
        check("b2b.t2.valid", 32'(bus_b.rsp_valid), 32'd1);
        check("b2b.t2.rdata", bus_b.rsp_rdata,      32'h0403_0201);
        tick();
        check("b2b.t3.ready", 32'(bus_b.req_ready), 32'd1);
        check("b2b.t3.valid", 32'(bus_b.rsp_valid), 32'd0);
        tick();
        drive_b(0, 0, 0, 0, 0, 0);
        check("b2b.t4.addr",  bus_b.mem_addr,       32'h014);
        tick();
        check("b2b.t5.valid", 32'(bus_b.rsp_valid), 32'd1);
        check("b2b.t5.rdata", bus_b.rsp_rdata,      32'h0807_0605);
        tick();
        check("b2b.t6.valid", 32'(bus_b.rsp_valid), 32'd0);
        check("b2b.t6.hold",  bus_b.rsp_rdata,      32'h0807_0605);

        // Misaligned disallowed: word at 0x002 and illegal size both fault
        drive_c(1, 0, 32'h002, 2'd2, 0, 32'h0);
        tick();
        drive_c(0, 0, 0, 0, 0, 0);
        check("c.mis.valid",   32'(bus_c.rsp_valid), 32'd1);
        check("c.mis.fault",   32'(bus_c.rsp_fault), 32'd1);
        check("c.mis.rdata",   bus_c.rsp_rdata,      32'd0);
        check("c.mis.mem_req", 32'(bus_c.mem_req),   32'd0);
        tick();
        check("c.mis.ready",   32'(bus_c.req_ready), 32'd1);
        drive_c(1, 0, 32'h000, 2'd3, 0, 32'h0);
        tick();
        drive_c(0, 0, 0, 0, 0, 0);
        check("c.sz3.valid",   32'(bus_c.rsp_valid), 32'd1);
        check("c.sz3.fault",   32'(bus_c.rsp_fault), 32'd1);
        check("c.sz3.mem_req", 32'(bus_c.mem_req),   32'd0);
        tick();

        // 16-bit bus: word read at 0x001 with 5 wait states on the 0x002 beat
        mem_a[10'h001] = 8'h11; mem_a[10'h002] = 8'h22; mem_a[10'h003] = 8'h33; mem_a[10'h004] = 8'h44;
        dly_addr_a = 32'h002;
        drive_a(1, 0, 32'h001, 2'd2, 0, 32'h0);
        tick();
        drive_a(0, 0, 0, 0, 0, 0);
        check_beat_a("ws.b0", 0, 32'h000, 2'b10, 16'h0000);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_beat_a("ws.b1", 0, 32'h002, 2'b11, 16'h0000);
            check("ws.b1.no_rsp", 32'(bus_a.rsp_valid), 32'd0);
        end
        tick();
        check_beat_a("ws.b2", 0, 32'h004, 2'b01, 16'h0000);
        tick();
        check("ws.valid", 32'(bus_a.rsp_valid), 32'd1);
        check("ws.rdata", bus_a.rsp_rdata,      32'h4433_2211);
        tick();

        // Same access, reset during the wait on the 0x002 beat
        drive_a(1, 0, 32'h001, 2'd2, 0, 32'h0);
        tick();
        drive_a(0, 0, 0, 0, 0, 0);
        tick();
        check_beat_a("rs.wait", 0, 32'h002, 2'b11, 16'h0000);
        reset = 1'b1;
        tick();
        check("rs.mem_req",   32'(bus_a.mem_req),   32'd0);
        check("rs.rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rs.ready_rst", 32'(bus_a.req_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("rs.ready",     32'(bus_a.req_ready), 32'd1);
        check("rs.no_rsp1",   32'(bus_a.rsp_valid), 32'd0);
        tick();
        check("rs.no_rsp2",   32'(bus_a.rsp_valid), 32'd0);
        check("rs.idle_req",  32'(bus_a.mem_req),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
Parametrised load/store alignment engine sitting between the CPU load/store path and a backing memory port of configurable width.
It splits any byte/half/word access into the minimum number of bus-aligned beats and assembles little-endian read data, with optional sign extension.
It raises a fault for illegal or (optionally) disallowed misaligned requests.
It replaces the fixed 16-bit split logic with a generic BUS_W-wide, ready/ack-handshaked design.

Parameters:
BUS_W, 16, backing memory data width in bits; legal values 16 or 32; B = BUS_W/8 byte lanes.
ADDR_W, 32, byte address width.
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = fault on any non-naturally-aligned access.

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_rw  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  in  1  reads: 1 = sign-extend, 0 = zero-extend; ignored for writes
req_wdata  in  32  write data, little-endian, low bytes used for byte/half
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  assembled, extended read data (0 for writes and faults)
rsp_fault  out  1  qualifies rsp_valid; request rejected, no memory beats issued
mem_req  out  1  beat request, held until mem_ack
mem_rw  out  1  beat direction
mem_addr  out  ADDR_W  beat address, always B-aligned
mem_be  out  B  byte-lane enables, bit i = lane i
mem_wdata  out  BUS_W  lane-positioned write data, unused lanes 0
mem_ack  in  1  beat complete; read data valid on mem_rdata in same cycle
mem_rdata  in  BUS_W  beat read data

Behaviour:
- Reset (synchronous, while reset=1 at a clk edge):
  - State goes to IDLE; rsp_valid, rsp_fault, mem_req, mem_rw, mem_be and mem_wdata go to 0; rsp_rdata goes to 0.
  - req_ready = (state==IDLE) && !reset.
  - Reset mid-access abandons the access: mem_req drops the cycle after reset is sampled, and no rsp_valid is produced.
  - Beats already acked are not rolled back.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Accept when req_valid && req_ready. Latch addr, size, rw, signed and wdata.
  - Fault if size==3, or if ALLOW_MISALIGNED==0 and addr is not a multiple of 2^size. A faulting request goes to RESP.
  - Otherwise compute nbeats = ceil(((addr mod B) + 2^size) / B), a value from 1 to 3, and go to ACCESS with beat=0.
- ACCESS:
  - mem_req=1, mem_addr = (addr & ~(B-1)) + beat*B.
  - mem_be = lanes covered by the access within this beat.
  - Request byte k goes to lane (addr+k) mod B of the beat containing byte address addr+k.
  - mem_addr, mem_be, mem_wdata and mem_rw stay stable until mem_ack.
  - On mem_ack, capture the enabled lanes of mem_rdata into the assembly register and increment beat.
  - After the ack of the last beat, go to RESP; mem_req drops in that cycle.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Reads: rsp_rdata is the assembled value, extended from bit 8*2^size-1 per req_signed.
  - Writes and faults: rsp_rdata=0; rsp_fault=1 only for faults.
- Outside RESP, rsp_rdata holds its last value.
- mem_ack outside ACCESS is ignored.
- Latency:
  - Zero-wait memory (ack in the same cycle as the first mem_req cycle): accept at cycle t, rsp_valid at t+1+nbeats. Each wait state adds one cycle.
  - Fault: rsp_valid at t+1.
- Throughput: req_ready is asserted only in IDLE. No overlap between consecutive requests.

Test Plan:
- BUS_W=16, write word 0xDDCCBBAA to 0x101 -> three beats: (0x100, be=10, wdata=0xAA00), (0x102, be=11, wdata=0xCCBB), (0x104, be=01, wdata=0x00DD); then rsp_valid with fault=0 and rdata=0.
- BUS_W=16, read byte at 0x203 with memory word at 0x202 = 0x8012 -> one beat at 0x202 with be=10; signed gives rsp_rdata=0xFFFFFF80, unsigned gives 0x00000080.
- BUS_W=32, unsigned half read at 0x007 with lane3 of 0x004 = 0x34 and lane0 of 0x008 = 0x12 -> beats 0x004 (be=1000) and 0x008 (be=0001); rsp_rdata=0x00001234.
- ALLOW_MISALIGNED=0, word read at 0x002, then req_size=3 at 0x000 -> no mem_req; each gives rsp_valid=1, rsp_fault=1, rsp_rdata=0 one cycle after accept.
- BUS_W=16, word read at 0x001 with mem_ack delayed 5 cycles on beat 1 -> mem_addr=0x002, be=11 and mem_req held stable for the whole wait. A second run asserts reset during that wait -> mem_req=0 next cycle, no rsp_valid, req_ready=1 the cycle after reset is released.
- Aligned word reads back-to-back, req_valid held high, zero-wait memory -> accepts at t0 and t3, rsp_valid at t2 and t5, req_ready low during t1..t2.
